axil_reg_slave: RTL and testbench

AXIL_REG_SLAVE -- requirements
Module: axil_reg_slave

---
 rtl/axil_pkg.sv | 27 ++
 rtl/axil_strb_merge.sv | 21 ++
 rtl/axil_reg_slave.sv | 265 ++++++++++++++++++++++++++
 tb/tb_axil_reg_slave.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_pkg.sv
// Shared types for the AXI-Lite register slave: response codes and
// the write/read channel state encodings.
package axil_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } axil_resp_e;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_ADDR,
        WR_DATA,
        WR_RESP
    } wr_state_e;

    typedef enum logic {
        RD_IDLE,
        RD_RESP
    } rd_state_e;

    // Number of byte-offset address bits for a given data bus width.
    function automatic int unsigned byte_off_bits(input int unsigned data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/axil_strb_merge.sv
// Byte-lane merge: each byte of the result comes from new_i when its
// strobe bit is set, otherwise from old_i.
module axil_strb_merge #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0]   old_i,
    input  logic [DATA_WIDTH-1:0]   new_i,
    input  logic [DATA_WIDTH/8-1:0] strb_i,
    output logic [DATA_WIDTH-1:0]   merged_o
);

    always_comb begin
        merged_o = old_i;
        for (int b = 0; b < DATA_WIDTH / 8; b++) begin
            if (strb_i[b]) begin
                merged_o[b*8 +: 8] = new_i[b*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/axil_reg_slave.sv
// AXI-Lite slave exposing NUM_REGS read/write registers with byte strobes,
// a flat register view and a per-register write pulse.
//
// state   | meaning
// --------+-----------------------------------------------------------
// WR_IDLE | no write in progress, accepting AW and W
// WR_ADDR | AW latched, waiting for W
// WR_DATA | W latched, waiting for AW
// WR_RESP | write committed, holding B until bready
// RD_IDLE | accepting AR
// RD_RESP | read data registered, holding R until rready
module axil_reg_slave
    import axil_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12,
    parameter int NUM_REGS   = 8
) (
    input  logic                           aclk,
    input  logic                           areset,

    input  logic [ADDR_WIDTH-1:0]          awaddr,
    input  logic [2:0]                     awprot,
    input  logic                           awvalid,
    output logic                           awready,

    input  logic [DATA_WIDTH-1:0]          wdata,
    input  logic [DATA_WIDTH/8-1:0]        wtrb,
    input  logic                           wvalid,
    output logic                           wready,

    output logic [1:0]                     bresp,
    output logic                           bvalid,
    input  logic                           bready,

    input  logic [ADDR_WIDTH-1:0]          araddr,
    input  logic [2:0]                     arprot,
    input  logic                           arvalid,
    output logic                           arready,

    output logic [DATA_WIDTH-1:0]          ardata,
    output logic [1:0]                     rresp,
    output logic                           rvalid,
    input  logic                           rready,

    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
    output logic [NUM_REGS-1:0]            wr_pulse_o
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int OFF_W  = int'(byte_off_bits(DATA_WIDTH));
    localparam int IDX_W  = ADDR_WIDTH - OFF_W;

    // ---------------------------------------------------------------
    // Write channel
    // ---------------------------------------------------------------
    wr_state_e             wr_state_q, wr_state_d;
    logic [IDX_W-1:0]      awidx_q, awidx_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0]     wstrb_q, wstrb_d;
    axil_resp_e            bresp_q, bresp_d;
    logic [NUM_REGS-1:0]   wr_pulse_q, wr_pulse_d;
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

    logic                  commit;
    logic [IDX_W-1:0]      commit_idx;
    logic [DATA_WIDTH-1:0] commit_data;
    logic [STRB_W-1:0]     commit_strb;
    logic [DATA_WIDTH-1:0] commit_old;
    logic [DATA_WIDTH-1:0] commit_merged;
    logic                  commit_hit;

    logic [IDX_W-1:0]      aw_in_idx;
    logic [IDX_W-1:0]      ar_in_idx;

    assign aw_in_idx = awaddr[ADDR_WIDTH-1:OFF_W];
    assign ar_in_idx = araddr[ADDR_WIDTH-1:OFF_W];

    always_comb begin
        wr_state_d  = wr_state_q;
        awidx_d     = awidx_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        commit      = 1'b0;
        commit_idx  = awidx_q;
        commit_data = wdata_q;
        commit_strb = wstrb_q;

        case (wr_state_q)
            WR_IDLE: begin
                if (awvalid && wvalid) begin
                    commit      = 1'b1;
                    commit_idx  = aw_in_idx;
                    commit_data = wdata;
                    commit_strb = wtrb;
                    wr_state_d  = WR_RESP;
                end else if (awvalid) begin
                    awidx_d    = aw_in_idx;
                    wr_state_d = WR_ADDR;
                end else if (wvalid) begin
                    wdata_d    = wdata;
                    wstrb_d    = wtrb;
                    wr_state_d = WR_DATA;
                end
            end
            WR_ADDR: begin
                if (wvalid) begin
                    commit      = 1'b1;
                    commit_idx  = awidx_q;
                    commit_data = wdata;
                    commit_strb = wtrb;
                    wr_state_d  = WR_RESP;
                end
            end
            WR_DATA: begin
                if (awvalid) begin
                    commit      = 1'b1;
                    commit_idx  = aw_in_idx;
                    commit_data = wdata_q;
                    commit_strb = wstrb_q;
                    wr_state_d  = WR_RESP;
                end
            end
            WR_RESP: begin
                if (bready) begin
                    wr_state_d = WR_IDLE;
                end
            end
            default: wr_state_d = WR_IDLE;
        endcase
    end

    // An index with no matching register is out of range; that alone
    // drives SLVERR and suppresses both the update and the pulse.
    always_comb begin
        commit_old = '0;
        commit_hit = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (commit_idx == IDX_W'(i)) begin
                commit_old = regs_q[i];
                commit_hit = 1'b1;
            end
        end
    end

    axil_strb_merge #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_strb_merge (
        .old_i    (commit_old),
        .new_i    (commit_data),
        .strb_i   (commit_strb),
        .merged_o (commit_merged)
    );

    always_comb begin
        regs_d     = regs_q;
        wr_pulse_d = '0;
        bresp_d    = bresp_q;
        if (commit) begin
            bresp_d = commit_hit ? RESP_OKAY : RESP_SLVERR;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (commit_idx == IDX_W'(i)) begin
                    regs_d[i]     = commit_merged;
                    wr_pulse_d[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_state_q <= WR_IDLE;
            awidx_q    <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bresp_q    <= RESP_OKAY;
            wr_pulse_q <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            wr_state_q <= wr_state_d;
            awidx_q    <= awidx_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            bresp_q    <= bresp_d;
            wr_pulse_q <= wr_pulse_d;
            regs_q     <= regs_d;
        end
    end

    assign awready    = (wr_state_q == WR_IDLE) || (wr_state_q == WR_DATA);
    assign wready     = (wr_state_q == WR_IDLE) || (wr_state_q == WR_ADDR);
    assign bvalid     = (wr_state_q == WR_RESP);
    assign bresp      = bresp_q;
    assign wr_pulse_o = wr_pulse_q;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_flat
        assign regs_o[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
    end

    // ---------------------------------------------------------------
    // Read channel (samples regs_q, so a same-cycle write is not seen)
    // ---------------------------------------------------------------
    rd_state_e             rd_state_q, rd_state_d;
    logic [DATA_WIDTH-1:0] ardata_q, ardata_d;
    axil_resp_e            rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0] rd_lookup;
    logic                  rd_hit;

    always_comb begin
        rd_lookup = '0;
        rd_hit    = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (ar_in_idx == IDX_W'(i)) begin
                rd_lookup = regs_q[i];
                rd_hit    = 1'b1;
            end
        end
    end

    always_comb begin
        rd_state_d = rd_state_q;
        ardata_d   = ardata_q;
        rresp_d    = rresp_q;
        case (rd_state_q)
            RD_IDLE: begin
                if (arvalid) begin
                    ardata_d   = rd_lookup;
                    rresp_d    = rd_hit ? RESP_OKAY : RESP_SLVERR;
                    rd_state_d = RD_RESP;
                end
            end
            RD_RESP: begin
                if (rready) begin
                    rd_state_d = RD_IDLE;
                end
            end
            default: rd_state_d = RD_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            rd_state_q <= RD_IDLE;
            ardata_q   <= '0;
            rresp_q    <= RESP_OKAY;
        end else begin
            rd_state_q <= rd_state_d;
            ardata_q   <= ardata_d;
            rresp_q    <= rresp_d;
        end
    end

    assign arready = (rd_state_q == RD_IDLE);
    assign rvalid  = (rd_state_q == RD_RESP);
    assign ardata  = ardata_q;
    assign rresp   = rresp_q;

    // Protection bits and byte-offset address bits carry no meaning here.
    logic unused_inputs;
    assign unused_inputs = ^{awprot, arprot, awaddr[OFF_W-1:0], araddr[OFF_W-1:0]};

endmodule

// File: tb/tb_axil_reg_slave.sv
// Directed bench for axil_reg_slave: a table of single-beat writes/reads
// followed by hand-written sequences for split handshakes, backpressure,
// read/write collision and mid-transaction reset.
module tb_axil_reg_slave;

    localparam int DW = 32;
    localparam int AW = 12;
    localparam int NR = 8;

    logic           aclk = 1'b0;
    logic           areset;
    logic [AW-1:0]  awaddr;
    logic [2:0]     awprot;
    logic           awvalid;
    logic           awready;
    logic [DW-1:0]  wdata;
    logic [DW/8-1:0] wtrb;
    logic           wvalid;
    logic           wready;
    logic [1:0]     bresp;
    logic           bvalid;
    logic           bready;
    logic [AW-1:0]  araddr;
    logic [2:0]     arprot;
    logic           arvalid;
    logic           arready;
    logic [DW-1:0]  ardata;
    logic [1:0]     rresp;
    logic           rvalid;
    logic           rready;
    logic [NR*DW-1:0] regs_o;
    logic [NR-1:0]  wr_pulse_o;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 aclk = ~aclk;

    axil_reg_slave #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .NUM_REGS   (NR)
    ) dut (
        .aclk       (aclk),
        .areset     (areset),
        .awaddr     (awaddr),
        .awprot     (awprot),
        .awvalid    (awvalid),
        .awready    (awready),
        .wdata      (wdata),
        .wtrb       (wtrb),
        .wvalid     (wvalid),
        .wready     (wready),
        .bresp      (bresp),
        .bvalid     (bvalid),
        .bready     (bready),
        .araddr     (araddr),
        .arprot     (arprot),
        .arvalid    (arvalid),
        .arready    (arready),
        .ardata     (ardata),
        .rresp      (rresp),
        .rvalid     (rvalid),
        .rready     (rready),
        .regs_o     (regs_o),
        .wr_pulse_o (wr_pulse_o)
    );

    typedef struct {
        bit          is_wr;
        logic [11:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rd;
        logic [7:0]  exp_pulse;
    } vec_t;

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] reg_word(input int i);
        return regs_o[i*DW +: DW];
    endfunction

    task automatic wr_both(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic seen, output logic [1:0] resp, output logic [7:0] pulse);
        int n;
        awaddr  = a;
        wdata   = d;
        wtrb    = s;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        tick();
        awvalid = 1'b0;
        wvalid  = 1'b0;
        n = 0;
        while (!bvalid && n < 8) begin
            tick();
            n++;
        end
        seen  = bvalid;
        resp  = bresp;
        pulse = wr_pulse_o;
        bready = 1'b1;
        tick();
        bready = 1'b0;
    endtask

    task automatic rd(input logic [11:0] a, output logic seen, output logic [1:0] resp,
                      output logic [31:0] d);
        int n;
        araddr  = a;
        arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 8) begin
            tick();
            n++;
        end
        seen = rvalid;
        resp = rresp;
        d    = ardata;
        rready = 1'b1;
        tick();
        rready = 1'b0;
    endtask

    vec_t        vecs [13];
    logic [31:0] exp_regs [NR];
    logic        seen;
    logic [1:0]  resp;
    logic [31:0] rdat;
    logic [7:0]  pulse;

    initial begin
        vecs[0]  = '{1'b1, 12'h004, 32'hDEADBEEF, 4'hF, 2'b00, 32'h0,        8'h02};
        vecs[1]  = '{1'b0, 12'h004, 32'h0,        4'h0, 2'b00, 32'hDEADBEEF, 8'h00};
        vecs[2]  = '{1'b1, 12'h000, 32'h11223344, 4'h5, 2'b00, 32'h0,        8'h01};
        vecs[3]  = '{1'b0, 12'h000, 32'h0,        4'h0, 2'b00, 32'h00220044, 8'h00};
        vecs[4]  = '{1'b1, 12'h01C, 32'hCAFEF00D, 4'hF, 2'b00, 32'h0,        8'h80};
        vecs[5]  = '{1'b0, 12'h01F, 32'h0,        4'h0, 2'b00, 32'hCAFEF00D, 8'h00};
        vecs[6]  = '{1'b1, 12'h00C, 32'h55555555, 4'h0, 2'b00, 32'h0,        8'h08};
        vecs[7]  = '{1'b0, 12'h00C, 32'h0,        4'h0, 2'b00, 32'h0,        8'h00};
        vecs[8]  = '{1'b1, 12'h020, 32'hFFFFFFFF, 4'hF, 2'b10, 32'h0,        8'h00};
        vecs[9]  = '{1'b0, 12'h020, 32'h0,        4'h0, 2'b10, 32'h0,        8'h00};
        vecs[10] = '{1'b0, 12'hFFC, 32'h0,        4'h0, 2'b10, 32'h0,        8'h00};
        vecs[11] = '{1'b1, 12'h006, 32'h0000AB00, 4'h2, 2'b00, 32'h0,        8'h02};
        vecs[12] = '{1'b0, 12'h004, 32'h0,        4'h0, 2'b00, 32'hDEADABEF, 8'h00};

        exp_regs[0] = 32'h00220044;
        exp_regs[1] = 32'hDEADABEF;
        exp_regs[2] = 32'h0;
        exp_regs[3] = 32'h0;
        exp_regs[4] = 32'h0;
        exp_regs[5] = 32'h0;
        exp_regs[6] = 32'h0;
        exp_regs[7] = 32'hCAFEF00D;

        areset  = 1'b1;
        awaddr  = '0; awprot = 3'b000; awvalid = 1'b0;
        wdata   = '0; wtrb   = '0;     wvalid  = 1'b0;
        bready  = 1'b0;
        araddr  = '0; arprot = 3'b010; arvalid = 1'b0;
        rready  = 1'b0;
        tick();
        tick();

        chk("reset bvalid",   64'(bvalid),     64'h0);
        chk("reset rvalid",   64'(rvalid),     64'h0);
        chk("reset bresp",    64'(bresp),      64'h0);
        chk("reset rresp",    64'(rresp),      64'h0);
        chk("reset ardata",   64'(ardata),     64'h0);
        chk("reset pulse",    64'(wr_pulse_o), 64'h0);
        chk("reset regs_or",  64'(|regs_o),    64'h0);

        areset = 1'b0;
        chk("post-reset readies", 64'({awready, wready, arready}), 64'h7);
        tick();

        for (int i = 0; i < 13; i++) begin
            if (vecs[i].is_wr) begin
                wr_both(vecs[i].addr, vecs[i].data, vecs[i].strb, seen, resp, pulse);
                chk($sformatf("v%0d bvalid", i), 64'(seen),  64'h1);
                chk($sformatf("v%0d bresp", i),  64'(resp),  64'(vecs[i].exp_resp));
                chk($sformatf("v%0d pulse", i),  64'(pulse), 64'(vecs[i].exp_pulse));
            end else begin
                rd(vecs[i].addr, seen, resp, rdat);
                chk($sformatf("v%0d rvalid", i), 64'(seen), 64'h1);
                chk($sformatf("v%0d rresp", i),  64'(resp), 64'(vecs[i].exp_resp));
                chk($sformatf("v%0d ardata", i), 64'(rdat), 64'(vecs[i].exp_rd));
            end
        end

        for (int i = 0; i < NR; i++) begin
            chk($sformatf("table reg%0d", i), 64'(reg_word(i)), 64'(exp_regs[i]));
        end

        // W first, AW three cycles later, partial strobe over all-ones.
        wr_both(12'h008, 32'hFFFFFFFF, 4'hF, seen, resp, pulse);
        chk("split prefill", 64'(reg_word(2)), 64'hFFFFFFFF);
        wdata  = 32'h12345678;
        wtrb   = 4'h3;
        wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        chk("split wr_data readies", 64'({awready, wready}), 64'h2);
        tick();
        tick();
        chk("split no early bvalid", 64'(bvalid), 64'h0);
        awaddr  = 12'h008;
        awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        chk("split bvalid/bresp", 64'({bvalid, bresp}), 64'h4);
        chk("split pulse",        64'(wr_pulse_o),      64'h04);
        chk("split reg2",         64'(reg_word(2)),     64'hFFFF5678);
        bready = 1'b1;
        tick();
        bready = 1'b0;
        chk("split pulse one cycle", 64'(wr_pulse_o), 64'h0);
        chk("split bvalid drop",     64'(bvalid),     64'h0);

        // B-channel backpressure.
        awaddr = 12'h010; wdata = 32'h0BADF00D; wtrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("stall c%0d", c), 64'({bvalid, bresp, awready, wready}), 64'h10);
            tick();
        end
        bready = 1'b1;
        tick();
        bready = 1'b0;
        chk("stall release", 64'({bvalid, awready, wready}), 64'h3);
        chk("stall reg4",    64'(reg_word(4)),              64'h0BADF00D);

        // Read in the same cycle as a write commit to the same register.
        wr_both(12'h004, 32'h00000001, 4'hF, seen, resp, pulse);
        awaddr = 12'h004; wdata = 32'hA5A5A5A5; wtrb = 4'hF;
        araddr = 12'h004;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        chk("collide rvalid", 64'(rvalid), 64'h1);
        chk("collide ardata", 64'(ardata), 64'h1);
        bready = 1'b1; rready = 1'b1;
        tick();
        bready = 1'b0; rready = 1'b0;
        rd(12'h004, seen, resp, rdat);
        chk("collide reread", 64'(rdat), 64'hA5A5A5A5);

        // Reset while write is in WR_ADDR and read is in RD_RESP.
        awaddr = 12'h014; awvalid = 1'b1;
        araddr = 12'h000; arvalid = 1'b1;
        tick();
        awvalid = 1'b0; arvalid = 1'b0;
        chk("pre-reset states", 64'({awready, wready, rvalid}), 64'h3);
        areset = 1'b1;
        wdata  = 32'hFFFFFFFF; wtrb = 4'hF; wvalid = 1'b1;
        tick();
        chk("midreset valids", 64'({bvalid, rvalid}), 64'h0);
        chk("midreset regs",   64'(|regs_o),          64'h0);
        chk("midreset pulse",  64'(wr_pulse_o),       64'h0);
        areset = 1'b0;
        wvalid = 1'b0;
        chk("release readies", 64'({awready, wready, arready}), 64'h7);
        tick();
        chk("release no commit", 64'({bvalid, wr_pulse_o, |regs_o}), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
